fetch_queue: RTL

//  Parametrised instruction-fetch front end: PC generator, in-order request/response imem port, DEPTH-entry decoded-ready FIFO.

---
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fetch_queue.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the fetch front end's handshake and bus signals.
//   redirect_valid/redirect_pc    EX-stage redirect strobe and target
//   imem_req_*                    in-order instruction memory request channel
//   imem_rsp_*                    instruction memory response channel (no ready)
//   out_*                         decoded-ready FIFO head towards IF/ID (valid/ready)
//   occupancy                     FIFO entry count
// Modports: master = fetch_queue side, slave = environment (EX, imem, IF/ID).
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [XLEN-1:0]          imem_req_addr;
    logic                     imem_rsp_valid;
    logic [XLEN-1:0]          imem_rsp_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_instr;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_pc4;
    logic                     out_pred_taken;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4,
               out_pred_taken, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc4,
               out_pred_taken, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Generates sequential PCs, issues them
// to an in-order imem port, and queues {instr, pc, pc+4} in a DEPTH-entry FIFO for
// the IF/ID stage. EX redirects flush the FIFO and mark every in-flight request
// stale; stale responses are counted off (drop_cnt) since memory cannot cancel.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    fetch_queue_if.master (redirect, imem req/rsp, FIFO head, occupancy)
// Optional feature: define FETCH_STATIC_PREDICT_EN to predict backward B-type
// branches and JAL as taken at response time; otherwise out_pred_taken is 0.
module fetch_queue #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] infl_pc [DEPTH];
    logic [AW-1:0]   infl_wr, infl_rd;
    logic [CW-1:0]   outstanding, drop_cnt, occ;
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    logic            rsp_fire, rsp_keep, pop, accept, pred_hit;
    logic [XLEN-1:0] rsp_pc;
    logic [CW:0]     credit_used;

    assign rsp_fire = bus.imem_rsp_valid & ~reset;
    assign rsp_pc   = infl_pc[infl_rd];
    // A response in a redirect cycle is stale even when drop_cnt is zero.
    assign rsp_keep = rsp_fire & ~bus.redirect_valid & (drop_cnt == '0);
    assign pop      = bus.out_valid & bus.out_ready & ~bus.redirect_valid;

    // Entries held plus live requests must fit, so a response never meets a full FIFO.
    assign credit_used = {1'b0, occ} + {1'b0, outstanding} - {1'b0, drop_cnt};

    assign bus.imem_req_valid = ~reset & ~bus.redirect_valid & ~pred_hit
                              & (outstanding < MAX_O) & (credit_used < DEPTH_C);
    assign accept             = bus.imem_req_valid & bus.imem_req_ready;
    assign bus.imem_req_addr  = pc;

`ifdef FETCH_STATIC_PREDICT_EN
    logic [DEPTH-1:0] fifo_pred;
    logic [XLEN-1:0]  rsp_instr, imm_b, imm_j, pred_target;
    logic             is_back_branch, is_jal;

    assign rsp_instr      = bus.imem_rsp_data;
    assign imm_b          = {{(XLEN-12){rsp_instr[31]}}, rsp_instr[7], rsp_instr[30:25],
                             rsp_instr[11:8], 1'b0};
    assign imm_j          = {{(XLEN-20){rsp_instr[31]}}, rsp_instr[19:12], rsp_instr[20],
                             rsp_instr[30:21], 1'b0};
    assign is_back_branch = (rsp_instr[6:0] == 7'b1100011) & rsp_instr[31];
    assign is_jal         = (rsp_instr[6:0] == 7'b1101111);
    assign pred_hit       = rsp_keep & (is_back_branch | is_jal);
    assign pred_target    = rsp_pc + (is_jal ? imm_j : imm_b);
    assign bus.out_pred_taken = bus.out_valid & fifo_pred[rd_ptr];
`else
    assign pred_hit           = 1'b0;
    assign bus.out_pred_taken = 1'b0;
`endif

    assign bus.out_valid = (occ != '0);
    assign bus.occupancy = occ;
    // Head fields read as zero while empty so stale array contents never leak out.
    assign bus.out_instr = bus.out_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.out_pc    = bus.out_valid ? fifo_pc[rd_ptr] : '0;
    assign bus.out_pc4   = bus.out_valid ? fifo_pc[rd_ptr] + XLEN'(4) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            infl_wr     <= '0;
            infl_rd     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (accept) begin
                infl_pc[infl_wr] <= pc;
                infl_wr          <= infl_wr + AW'(1);
            end
            if (rsp_fire) begin
                infl_rd <= infl_rd + AW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp_fire);

            if (bus.redirect_valid) begin
                // No issue this cycle, so every request still in flight after the edge is stale.
                pc       <= bus.redirect_pc & ~XLEN'(3);
                drop_cnt <= outstanding - CW'(rsp_fire);
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
`ifdef FETCH_STATIC_PREDICT_EN
                if (pred_hit) begin
                    pc       <= pred_target;
                    drop_cnt <= outstanding - CW'(1);
                end else if (accept) begin
                    pc <= pc + XLEN'(4);
                end
`else
                if (accept) begin
                    pc <= pc + XLEN'(4);
                end
`endif
                if (rsp_fire && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (rsp_keep) begin
                    fifo_instr[wr_ptr] <= bus.imem_rsp_data;
                    fifo_pc[wr_ptr]    <= rsp_pc;
`ifdef FETCH_STATIC_PREDICT_EN
                    fifo_pred[wr_ptr]  <= pred_hit;
`endif
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                occ <= occ + CW'(rsp_keep) - CW'(pop);
            end
        end
    end
endmodule
